demux12_reg: RTL
================

// Module: demux12_reg
// PURPOSE
//   Registered 1-to-2 demultiplexer with valid/ready handshakes. This is the inverse of the
//   2-1 mux used on the ALU operand path: it steers one WIDTH-bit result word to destination
//   port 0 or port 1, selected by s. Each destination has its own one-entry holding register,
//   so a stalled consumer on one port never blocks words headed for the other port.
// PARAMETERS
//   WIDTH  4  data width of the input word and of each output port
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst        in   1      asynchronous, active-high reset
//   d          in   WIDTH  input data word
//   s          in   1      destination select: 0 -> out0, 1 -> out1
//   in_valid   in   1      producer presents d/s
//   in_ready   out  1      a word is accepted on a cycle where in_valid && in_ready
//   out0       out  WIDTH  port 0 data (registered)
//   out0_valid out  1      port 0 holds an undelivered word
//   out0_ready in   1      port 0 consumer takes the word on a cycle where out0_valid && out0_ready
//   out1       out  WIDTH  port 1 data (registered)
//   out1_valid out  1      port 1 holds an undelivered word
//   out1_ready in   1      port 1 consumer takes the word on a cycle where out1_valid && out1_ready
//   cnt0, cnt1 out  8      delivered-word counters (only when DEMUX_STATS_EN is defined)
// BEHAVIOUR
//   Reset: all outputs go to 0 immediately (out0, out1, valids, cnt*). Both slots are EMPTY.
//     If reset is asserted mid-transfer, held words are discarded with no delivery.
//   Per-port state machine, two states:
//     EMPTY -> FULL   on accept with s==k
//     FULL  -> EMPTY  on drain (outk_valid && outk_ready) with no accept to port k
//     FULL  -> FULL   on drain and accept to port k in the same cycle; the new word replaces the old
//   in_ready is combinational: s ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready).
//     It never depends on in_valid.
//   On accept: outs <= d and outs_valid <= 1, so data appears the cycle after the accept edge
//     (latency 1). The other port's data and valid are left untouched.
//   A slot's data is held stable while it is FULL and not drained. A drained slot keeps its
//     last data value; only its valid is cleared.
//   Both ports may drain in the same cycle. Throughput is 1 word/cycle when the selected
//     consumer is ready.
//   Producer rule: d and s must stay stable while in_valid && !in_ready. The TB asserts this;
//     the RTL does not check it.
//   Data passes through bit-exact. There is no arithmetic and no width conversion.
// CONFIGURATION
//   DEMUX_STATS_EN defined:
//     cnt0/cnt1 count completed deliveries per port and saturate at 8'hFF (no wrap).
//     They reset to 0 asynchronously on rst.
//   DEMUX_STATS_EN undefined:
//     cnt0/cnt1 ports and their counter logic are absent. All other behaviour is identical.
// STRUCTURE
//   Shared include demux_defs.vh: `define DEMUX_SEL_P0 1'b0, `define DEMUX_SEL_P1 1'b1,
//     and the counter width `define DEMUX_CNT_W 8.
//   Sub-module demux_slot: one per port, instantiated twice.
//     Contains the WIDTH-bit holding register, the valid flag, drain/load logic and the
//     optional counter.
//   Top level: select decode, in_ready mux, and the two demux_slot instances.
// TESTING
//   1. Reset: assert rst mid-cycle with both slots FULL -> all outputs are 0 asynchronously
//      (before the next clk edge); in_ready=1 after release.
//   2. Steering: d=4'hA,s=0 then d=4'h5,s=1, both consumers ready -> out0=A and out1=5, each
//      one cycle after its accept; the other port is unchanged.
//   3. Backpressure: out0_ready=0, send 4'h3 to port 0 and then offer 4'h7 to port 0 ->
//      in_ready=0, out0 holds 3. Raise out0_ready -> 3 drains, 7 is accepted the same cycle,
//      and out0=7 next.
//   4. Independence: port 0 stalled and FULL, offer 4'hC to port 1 -> accepted immediately,
//      out1=C; out0 is unaffected.
//   5. Streaming: 16 words with s alternating 0/1, both ready -> 16 accepts in 16 cycles with no
//      bubbles; per-port data order is preserved.
//   6. With DEMUX_STATS_EN: 300 deliveries to port 1 -> cnt1=8'hFF (saturated), cnt0=0;
//      rst clears both counters.

Source files
------------

// File: rtl/demux12_reg_pkg.sv
// demux12_reg_pkg
//   Types and helpers shared by the demux12_reg top and its demux_slot sub-module.
//   slot_state_e : per-port holding-register state (EMPTY / FULL).
//   CNT_W        : width of the delivered-word counters (only used when DEMUX_STATS_EN is defined).
//   sat_inc      : saturating increment for those counters.
`include "demux_defs.vh"

package demux12_reg_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int CNT_W = `DEMUX_CNT_W;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        result = value;
        if (value != {CNT_W{1'b1}}) begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_defs.vh
// demux_defs.vh
//   Shared defines for the demux12_reg block.
//   DEMUX_SEL_P0 / DEMUX_SEL_P1 : select values that steer a word to port 0 / port 1.
//   DEMUX_CNT_W                 : width of the optional delivered-word counters.
`ifndef DEMUX_DEFS_VH
`define DEMUX_DEFS_VH

`define DEMUX_SEL_P0 1'b0
`define DEMUX_SEL_P1 1'b1
`define DEMUX_CNT_W 8

`endif

// File: rtl/demux_slot.sv
// demux_slot
//   One destination slot of the registered demux: a single-entry holding register with
//   a valid flag, valid/ready drain logic and an optional saturating delivery counter.
//   Optional feature macro: DEMUX_STATS_EN (adds the cnt output and its counter).
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   top-level accept steered to this slot (only asserted when slot_ready)
//   load_data  in   WIDTH-bit word to capture on load
//   slot_ready out  slot can take a word this cycle (empty, or being drained)
//   out_data   out  registered data word
//   out_valid  out  slot holds an undelivered word
//   out_ready  in   consumer takes the word when out_valid && out_ready
//   cnt        out  delivered-word count, saturating (DEMUX_STATS_EN only)
`include "demux_defs.vh"

module demux_slot
    import demux12_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             slot_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             drain;

    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;
    assign drain      = out_valid && out_ready;
    // A word leaving this cycle frees the slot, so a new one can land on the same edge.
    assign slot_ready = !out_valid || out_ready;

    // Next-state: a load always wins (covers both EMPTY->FULL and drain+reload),
    // otherwise a drain empties the slot but leaves the last data word in place.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot state and holding register; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt = cnt_q;

    // Count completed deliveries only; accepts are not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Delivery counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/demux12_reg.sv
// demux12_reg
//   Registered 1-to-2 demultiplexer with valid/ready handshakes. A word on d is steered to
//   port 0 or port 1 by s; each port has its own one-entry slot so a stalled consumer on one
//   port never blocks traffic to the other.
//   Optional feature macro: DEMUX_STATS_EN (adds cnt0/cnt1 delivered-word counters).
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   d, s, in_valid        producer word, destination select (0 -> out0, 1 -> out1), valid
//   in_ready              word accepted when in_valid && in_ready (independent of in_valid)
//   out0, out0_valid      port 0 registered data and valid
//   out0_ready            port 0 consumer ready
//   out1, out1_valid      port 1 registered data and valid
//   out1_ready            port 1 consumer ready
//   cnt0, cnt1            per-port delivered-word counters, saturating (DEMUX_STATS_EN only)
`include "demux_defs.vh"

module demux12_reg
    import demux12_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [`DEMUX_CNT_W-1:0] cnt0,
    output logic [`DEMUX_CNT_W-1:0] cnt1
`endif
);

    logic sel_p0;
    logic sel_p1;
    logic ready0;
    logic ready1;
    logic accept;
    logic load0;
    logic load1;

    assign sel_p0 = (s == `DEMUX_SEL_P0);
    assign sel_p1 = (s == `DEMUX_SEL_P1);

    // Readiness follows only the selected slot, so in_ready never depends on in_valid.
    assign in_ready = sel_p1 ? ready1 : ready0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && sel_p0;
    assign load1    = accept && sel_p1;

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load0),
        .load_data  (d),
        .slot_ready (ready0),
        .out_data   (out0),
        .out_valid  (out0_valid),
        .out_ready  (out0_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt        (cnt0)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load1),
        .load_data  (d),
        .slot_ready (ready1),
        .out_data   (out1),
        .out_valid  (out1_valid),
        .out_ready  (out1_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt        (cnt1)
`endif
    );

endmodule
